// File: rtl/fp_pkg.sv
// Shared constants and types for the binary32 adder's normalize/round stages.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  // Raw mantissa field indices: carry-out, hidden bit, then guard/round/sticky.
  localparam int CARRY   = 27;
  localparam int HID     = 26;
  localparam int LSB_BIT = 3;
  localparam int G_BIT   = 2;
  localparam int R_BIT   = 1;
  localparam int S_BIT   = 0;

  // out_flags = {overflow, underflow, inexact, zero}
  localparam int F_OVF  = 3;
  localparam int F_UNF  = 2;
  localparam int F_INX  = 1;
  localparam int F_ZERO = 0;

  typedef struct packed {
    logic               sign;
    logic signed [9:0]  exp10;
    logic [26:0]        mant27;
    logic [3:0]         flags;
  } s1_payload_t;

endpackage

// File: rtl/fp_lzc27.sv
// Combinational leading-zero counter over a 27-bit mantissa (bit 26 is the MSB).
module fp_lzc27 (
  input  logic [26:0] val,
  output logic [4:0]  lz,
  output logic        all_zero
);

  always_comb begin
    lz = 5'd0;
    // Scan upward so the highest set bit is the last one to assign.
    for (int i = 0; i < 27; i++) begin
      if (val[i]) lz = 5'(26 - i);
    end
    all_zero = ~|val;
  end

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalize (stage 1) and round-to-nearest-even (stage 2) pipeline
// producing a packed binary32 result with status flags.
module fp_norm_round
  import fp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [27:0]             in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic [3:0]              out_flags
);

  logic                   s1_valid_q, s1_valid_d;
  s1_payload_t            s1_q, s1_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [EXP_W+FRAC_W:0]  result_q, result_d;
  logic [3:0]             flags_q, flags_d;

  logic adv1, adv2;

  assign adv2      = !s2_valid_q || out_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;

  // ---------------- stage 1: normalize ----------------
  logic [4:0]        lz;
  logic              mant_lo_zero;
  logic signed [9:0] e_in, e_norm;
  s1_payload_t       norm;

  fp_lzc27 u_lzc (
    .val      (in_mant[HID:0]),
    .lz       (lz),
    .all_zero (mant_lo_zero)
  );

  always_comb begin
    e_in        = $signed({2'b00, in_exp});
    e_norm      = e_in;
    norm.sign   = in_sign;
    norm.exp10  = e_in;
    norm.mant27 = '0;
    norm.flags  = '0;
    if (mant_lo_zero && !in_mant[CARRY]) begin
      norm.sign          = 1'b0;
      norm.exp10         = '0;
      norm.flags[F_ZERO] = 1'b1;
    end else begin
      if (in_mant[CARRY]) begin
        // Right shift folds the dropped round bit into sticky.
        norm.mant27 = {in_mant[CARRY:LSB_BIT-1], in_mant[R_BIT] | in_mant[S_BIT]};
        e_norm      = e_in + 10'sd1;
      end else begin
        norm.mant27 = in_mant[HID:0] << lz;
        e_norm      = e_in - $signed({5'd0, lz});
      end
      norm.exp10 = e_norm;
      if (e_norm <= 10'sd0) begin
        norm.mant27        = '0;
        norm.exp10         = '0;
        norm.flags[F_UNF]  = 1'b1;
        norm.flags[F_INX]  = 1'b1;
        norm.flags[F_ZERO] = 1'b1;
      end
    end
  end

  // ---------------- stage 2: round ----------------
  logic                  round_up, inexact;
  logic [23:0]           frac_inc;
  logic signed [9:0]     e_rnd;
  logic [EXP_W+FRAC_W:0] rnd_result;
  logic [3:0]            rnd_flags;

  always_comb begin
    inexact  = s1_q.mant27[G_BIT] | s1_q.mant27[R_BIT] | s1_q.mant27[S_BIT];
    round_up = s1_q.mant27[G_BIT] &
               (s1_q.mant27[R_BIT] | s1_q.mant27[S_BIT] | s1_q.mant27[LSB_BIT]);
    frac_inc = {1'b0, s1_q.mant27[HID-1:LSB_BIT]} + 24'(round_up);
    e_rnd    = s1_q.exp10 + $signed({9'd0, frac_inc[FRAC_W]});
    rnd_result = '0;
    rnd_flags  = '0;
    // Normalized payloads always carry the hidden bit; its absence marks the zero/flush path.
    if (!s1_q.mant27[HID]) begin
      rnd_result = {s1_q.sign, 31'd0};
      rnd_flags  = s1_q.flags;
    end else if (e_rnd >= $signed(10'(EXP_MAX))) begin
      rnd_result       = {s1_q.sign, 8'hFF, 23'd0};
      rnd_flags[F_OVF] = 1'b1;
      rnd_flags[F_INX] = 1'b1;
    end else begin
      rnd_result       = {s1_q.sign, e_rnd[EXP_W-1:0], frac_inc[FRAC_W-1:0]};
      rnd_flags[F_INX] = inexact;
    end
  end

  // ---------------- pipeline registers ----------------
  always_comb begin
    s1_valid_d = adv1 ? in_valid : s1_valid_q;
    s1_d       = (adv1 && in_valid) ? norm : s1_q;
    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    result_d   = (adv2 && s1_valid_q) ? rnd_result : result_q;
    flags_d    = (adv2 && s1_valid_q) ? rnd_flags : flags_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench: value-level RNE model, scoreboard compare and directed handshake checks.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = 8'd0;
  logic [27:0] in_mant = 28'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  fp_norm_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_popped = 0;
  logic [35:0] exp_q[$];
  logic        hold_vld = 1'b0;
  logic [35:0] hold_val = '0;
  logic        rand_rdy = 1'b0;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [35:0] x;   // {flags, result}
  } vec_t;
  vec_t vecs [0:10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Value-level model: locate the leading one, keep 24 significant bits,
  // round the discarded remainder to nearest-even.
  function automatic logic [35:0] model(input logic s, input logic [7:0] e, input logic [27:0] m);
    int p, ee, sh;
    longint mm, kept, rem, half;
    logic up, inx;
    if (m == 28'd0) return {4'b0001, 32'h0};
    mm = longint'(m);
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    ee = int'(e) + p - 26;
    if (ee <= 0) return {4'b0111, s, 31'h0};
    if (p >= 23) begin
      sh   = p - 23;
      kept = mm >> sh;
      rem  = mm & ((64'sd1 << sh) - 1);
      half = (sh > 0) ? (64'sd1 << (sh - 1)) : 0;
    end else begin
      sh   = 0;
      kept = mm << (23 - p);
      rem  = 0;
      half = 0;
    end
    inx = (rem != 0);
    up  = (rem > half) || (rem == half && rem != 0 && kept[0]);
    kept = kept + longint'(up);
    if (kept == (64'sd1 << 24)) begin
      kept = kept >> 1;
      ee++;
    end
    if (ee >= 255) return {4'b1010, s, 8'hFF, 23'h0};
    return {2'b00, inx, 1'b0, s, 8'(ee), 23'(kept)};
  endfunction

  // Scoreboard: push on accept, pop and compare on emit, check hold during stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_vld = 1'b0;
    end else begin
      if (out_valid && hold_vld) chk("hold_stable", {out_flags, out_result}, hold_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got %h required none", {out_flags, out_result});
        end else begin
          chk("result", {out_flags, out_result}, exp_q.pop_front());
          n_popped++;
          $display("out %0d: result=%h flags=%b", n_popped, out_result, out_flags);
        end
      end
      hold_vld = out_valid && !out_ready;
      hold_val = {out_flags, out_result};
      if (in_valid && in_ready) exp_q.push_back(model(in_sign, in_exp, in_mant));
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m);
    logic acc;
    int n;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 required 1 within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", {32'(exp_q.size()), 31'd0, out_valid}, 64'd0);
  endtask

  initial begin
    logic        acc;
    int          accepted, guard;
    logic [27:0] rm;

    vecs[0]  = {1'b0, 8'd127, 28'h8000000, 4'h0, 32'h40000000};
    vecs[1]  = {1'b0, 8'd127, 28'h0200000, 4'h0, 32'h3D000000};
    vecs[2]  = {1'b0, 8'd127, 28'h4000004, 4'h2, 32'h3F800000};
    vecs[3]  = {1'b0, 8'd127, 28'h400000C, 4'h2, 32'h3F800002};
    vecs[4]  = {1'b0, 8'd254, 28'h7FFFFFC, 4'hA, 32'h7F800000};
    vecs[5]  = {1'b0, 8'd3,   28'h0200000, 4'h7, 32'h00000000};
    vecs[6]  = {1'b1, 8'd100, 28'h0000000, 4'h1, 32'h00000000};
    vecs[7]  = {1'b1, 8'd130, 28'h8000003, 4'h2, 32'hC1800000};
    vecs[8]  = {1'b0, 8'd127, 28'h4000006, 4'h2, 32'h3F800001};
    vecs[9]  = {1'b1, 8'd1,   28'h2000000, 4'h7, 32'h80000000};
    vecs[10] = {1'b0, 8'd255, 28'h4000000, 4'hA, 32'h7F800000};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, in_ready, out_flags, out_result}, {1'b0, 1'b1, 4'h0, 32'h0});
    rst_n = 1'b1;

    // pin the model to hand-computed values
    for (int i = 0; i < 11; i++)
      chk($sformatf("model_v%0d", i), model(vecs[i].s, vecs[i].e, vecs[i].m), vecs[i].x);

    // latency: out_valid one edge after the accepting edge
    out_ready = 1'b1;
    send(vecs[0].s, vecs[0].e, vecs[0].m);
    chk("latency_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("latency_due", out_valid, 1);
    drain();

    // directed vectors back to back
    for (int i = 0; i < 11; i++) send(vecs[i].s, vecs[i].e, vecs[i].m);
    drain();

    // backpressure: 4 inputs, output stalled for 5 cycles
    out_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_sign  = vecs[accepted].s;
      in_exp   = vecs[accepted].e;
      in_mant  = vecs[accepted].m;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) accepted++;
    end
    chk("bp_accepted", accepted, 2);
    chk("bp_ready_valid", {in_ready, out_valid}, 2'b01);
    out_ready = 1'b1;
    guard = 0;
    while (accepted < 4 && guard < 50) begin
      in_sign = vecs[accepted].s;
      in_exp  = vecs[accepted].e;
      in_mant = vecs[accepted].m;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) accepted++;
      guard++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", accepted, 4);
    drain();

    // pseudo-random operands with random downstream stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rm = 28'($urandom);
      rm = rm >> $urandom_range(0, 27);
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), rm);
    end
    rand_rdy = 1'b0;
    #2;
    out_ready = 1'b1;
    drain();

    // asynchronous reset with both stages full
    out_ready = 1'b0;
    send(vecs[1].s, vecs[1].e, vecs[1].m);
    send(vecs[2].s, vecs[2].e, vecs[2].m);
    chk("pre_reset_full", {out_valid, in_ready}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {out_valid, out_flags, out_result}, 37'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(vecs[3].s, vecs[3].e, vecs[3].m);
    chk("post_reset_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("post_reset_due", {out_valid, out_flags, out_result}, {1'b1, vecs[3].x});
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Final normalize-and-round stage of the single-precision FP add pipeline.
- Consumes the raw mantissa sum, exponent and sign from the mantissa add/sub stage.
- Produces a packed IEEE-754 binary32 result with round-to-nearest-even and status flags.
- Two-stage pipeline with valid/ready handshaking on both sides; supports backpressure without data loss.

Parameters:
- EXP_W, 8, exponent width (fixed for binary32; other values unsupported).
- FRAC_W, 23, stored fraction width (fixed for binary32; other values unsupported).

Ports:
- clk  input  1  clock (all flops rising-edge).
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operand valid.
- in_ready  output  1  stage accepts operand this cycle.
- in_sign  input  1  result sign from add/sub stage.
- in_exp  input  8  biased exponent of larger operand.
- in_mant  input  28  [27] carry-out, [26] hidden-bit position, [25:3] fraction, [2] guard, [1] round, [0] sticky.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  32  {sign, exp[7:0], frac[22:0]}.
- out_flags  output  4  {overflow, underflow, inexact, zero}.

Behaviour:
- Reset (async assert, sync release): stage valids, out_valid, out_result and out_flags all 0. Reset mid-operation discards in-flight results.
- Handshake:
  - adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1.
  - Transfer occurs on in_valid & in_ready, or on out_valid & out_ready.
  - Latency: 2 cycles from accepted input to out_valid with no stall. Throughput: 1 per cycle.
  - out_result and out_flags hold stable while out_valid & !out_ready.
- Stage 1 (normalize), using a 10-bit signed internal exponent E = in_exp:
  - in_mant == 0: zero result, sign forced to 0; flags zero=1, others 0.
  - in_mant[27] = 1: shift right 1, new sticky = old R | old S, E = E + 1.
  - Otherwise: lz = leading zeros from bit 26 (0..26); shift left lz, zero-fill; E = E - lz.
  - E <= 0 after adjustment: flush to signed zero (no denormals); flags underflow=1, inexact=1, zero=1.
- Stage 2 (round, RNE):
  - lsb = bit 3, G = bit 2, R = bit 1, S = bit 0.
  - Round up iff G & (R | S | lsb); inexact = G | R | S.
  - Round-up carry out of fraction: fraction = 0, E = E + 1.
  - E >= 255 (including in_exp == 255 input): out = {sign, 8'hFF, 23'h0}; overflow=1, inexact=1.
- Flags are per-result and not sticky; the underflow/zero path bypasses rounding.
- A simultaneous accept and emit in the same cycle is legal and must not drop or duplicate data.

Decomposition:
- Shared package fp_pkg:
  - constants EXP_W, FRAC_W, BIAS = 127, EXP_MAX = 255;
  - mantissa field indices (CARRY = 27, HID = 26, G/R/S);
  - flag bit positions;
  - typedef of the stage-1 payload struct {sign, exp10, mant27, flags}.
- One sub-module, fp_lzc27: combinational leading-zero counter over bits 26:0, output 5-bit count plus an all-zero flag. Reused by the subtract path.

Test Plan:
- Sign 0, exp 127, in_mant = 28'h8000000 -> after 2 cycles out_result = 32'h40000000, flags = 0.
- Exp 127, in_mant = 28'h0200000 (lz = 5) -> 32'h3D000000, flags = 0.
- Exp 127, in_mant = 28'h4000004 (tie, lsb 0) -> 32'h3F800000, inexact; in_mant = 28'h400000C -> 32'h3F800002, inexact.
- Exp 254, in_mant = 28'h7FFFFFC -> 32'h7F800000, overflow = 1, inexact = 1. Exp 3, in_mant = 28'h0200000 -> 32'h00000000, underflow = 1, inexact = 1, zero = 1. in_mant = 0 -> 32'h00000000, zero only.
- Backpressure: push 4 back-to-back inputs with out_ready = 0 for 5 cycles -> in_ready deasserts after 2 accepted, outputs held stable; on release all results emerge in order, none lost or duplicated.
- Assert rst_n low for 1 cycle with both stages full -> out_valid = 0 immediately (async); first post-reset input emerges exactly 2 cycles after acceptance.
